// File: rtl/onehot_scan_encoder_pkg.sv
// ---------------------------------------------------------------------------
// onehot_scan_encoder_pkg
//   Shared definitions for the one-hot scan encoder slice:
//     - IDX_W_DEFAULT : default index width (vector width is 1 << IDX_W)
//     - state_t       : scan FSM state encoding (ST_IDLE / ST_EMIT / ST_DONE)
//     - vec_width()   : derives the request-vector width from the index width
// ---------------------------------------------------------------------------
package onehot_scan_encoder_pkg;

  localparam int IDX_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Every index 0 .. VEC_W-1 fits IDX_W bits exactly.
  function automatic int vec_width(input int idx_w);
    return 1 << idx_w;
  endfunction

endpackage

// File: rtl/onehot_scan_encoder_prio_enc_lsb.sv
// ---------------------------------------------------------------------------
// prio_enc_lsb
//   Purely combinational priority encoder: the lowest set bit wins.
//   Ports:
//     vec  in  VEC_W  vector to encode
//     idx  out IDX_W  index of the lowest set bit (0 when vec is zero)
//     any  out 1      vec has at least one bit set
// ---------------------------------------------------------------------------
module prio_enc_lsb
  import onehot_scan_encoder_pkg::*;
#(
  parameter  int IDX_W = IDX_W_DEFAULT,
  localparam int VEC_W = vec_width(IDX_W)
) (
  input  logic [VEC_W-1:0] vec,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the block leaves a variable unassigned and no latch is inferred.
  always_comb begin
    idx = '0;
    any = |vec;
    // Scan from the top down so the last hit, i.e. the lowest bit, wins.
    for (int i = VEC_W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/onehot_scan_encoder.sv
// ---------------------------------------------------------------------------
// onehot_scan_encoder
//   Takes a request vector and emits the binary index of each set bit,
//   lowest first, one per valid/ready handshake, then pulses done with the
//   number of indices emitted.
//   Ports:
//     clock       in  1        rising-edge clock
//     reset       in  1        asynchronous, active-high reset
//     vec_in      in  VEC_W    request vector, taken when vec_load & load_ready
//     vec_load    in  1        load strobe
//     load_ready  out 1        high only while idle
//     idx_out     out IDX_W    index of the current lowest pending bit
//     idx_valid   out 1        idx_out is valid
//     idx_ready   in  1        consumer takes idx_out this cycle
//     done        out 1        one-cycle pulse after the vector is drained
//     count_out   out IDX_W+1  indices emitted for the last vector
// ---------------------------------------------------------------------------
module onehot_scan_encoder
  import onehot_scan_encoder_pkg::*;
#(
  parameter  int IDX_W = IDX_W_DEFAULT,
  localparam int VEC_W = vec_width(IDX_W)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [VEC_W-1:0] vec_in,
  input  logic             vec_load,
  output logic             load_ready,
  output logic [IDX_W-1:0] idx_out,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic             done,
  output logic [IDX_W:0]   count_out
);

  state_t           state, state_n;
  logic [VEC_W-1:0] pending, pending_n;
  logic [IDX_W-1:0] idx_n;
  logic             valid_n;
  logic [IDX_W:0]   cnt, cnt_n;

  // Pending vector with the currently presented index removed; this is what
  // remains once the consumer takes idx_out.
  logic [VEC_W-1:0] pending_clr;
  logic [IDX_W-1:0] load_idx, acc_idx;
  logic             load_any, acc_any;

  assign pending_clr = pending & ~(VEC_W'(1) << idx_out);

  prio_enc_lsb #(.IDX_W(IDX_W)) u_enc_load (
    .vec (vec_in),
    .idx (load_idx),
    .any (load_any)
  );

  prio_enc_lsb #(.IDX_W(IDX_W)) u_enc_acc (
    .vec (pending_clr),
    .idx (acc_idx),
    .any (acc_any)
  );

  // NOTE: state, pending bits and outputs are all flops with a defined reset
  // value, so an abort mid-scan leaves nothing stale behind; non-blocking
  // assignments keep every flop updating from the pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      pending   <= '0;
      idx_out   <= '0;
      idx_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      pending   <= pending_n;
      idx_out   <= idx_n;
      idx_valid <= valid_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n   = state;
    pending_n = pending;
    idx_n     = idx_out;
    valid_n   = idx_valid;
    cnt_n     = cnt;

    unique case (state)
      ST_IDLE: begin
        if (vec_load) begin
          cnt_n = '0;
          if (load_any) begin
            pending_n = vec_in;
            idx_n     = load_idx;
            valid_n   = 1'b1;
            state_n   = ST_EMIT;
          end else begin
            // Empty vector: nothing to emit, report a zero count straight away.
            state_n = ST_DONE;
          end
        end
      end

      ST_EMIT: begin
        // vec_load is ignored here; only a transfer advances the scan.
        if (idx_valid && idx_ready) begin
          pending_n = pending_clr;
          cnt_n     = cnt + (IDX_W + 1)'(1);
          if (acc_any) begin
            idx_n = acc_idx;
          end else begin
            // idx_out keeps its last value once valid drops.
            valid_n = 1'b0;
            state_n = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_n = ST_IDLE;
      end

      default: begin
        state_n   = ST_IDLE;
        pending_n = '0;
        valid_n   = 1'b0;
      end
    endcase
  end

  // Decoded from the state register, so reset clears them without a cycle
  // of delay and a mid-scan reset never produces a done pulse.
  assign load_ready = (state == ST_IDLE);
  assign done       = (state == ST_DONE);
  assign count_out  = cnt;

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// ---------------------------------------------------------------------------
// tb_onehot_scan_encoder
//   Self-checking bench: a vector table, hand-written corner sequences and
//   randomized vectors with random consumer back-pressure. Expected indices
//   and counts come from the set bits of each vector.
// ---------------------------------------------------------------------------
module tb_onehot_scan_encoder;

  localparam int IDX_W = 4;
  localparam int VEC_W = 16;

  logic             clock;
  logic             reset;
  logic [VEC_W-1:0] vec_in;
  logic             vec_load;
  logic             load_ready;
  logic [IDX_W-1:0] idx_out;
  logic             idx_valid;
  logic             idx_ready;
  logic             done;
  logic [IDX_W:0]   count_out;

  onehot_scan_encoder #(.IDX_W(IDX_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .vec_in     (vec_in),
    .vec_load   (vec_load),
    .load_ready (load_ready),
    .idx_out    (idx_out),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .done       (done),
    .count_out  (count_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  int got_q[$];
  int exp_q[$];
  bit ready_pat[$];
  int got_cnt;
  int cycles;

  typedef struct {
    logic [15:0] vec;
    int          exp_cnt;
    int          exp_first;
    int          exp_last;
  } vec_rec_t;

  vec_rec_t tbl[$];

  task automatic check(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  // Reference: indices of the set bits, ascending.
  task automatic build_expected(input logic [15:0] v);
    exp_q.delete();
    for (int i = 0; i < VEC_W; i++) begin
      if (v[i]) exp_q.push_back(i);
    end
  endtask

  task automatic compare_lists(input string name);
    check({name, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s_idx%0d", name, i), got_q[i], exp_q[i]);
    end
    check({name, "_count"}, got_cnt, exp_q.size());
  endtask

  // Called at a negedge while idle; returns at the negedge after the load edge.
  task automatic drive_load(input logic [15:0] v);
    check("load_ready_before_load", load_ready, 1);
    vec_in   = v;
    vec_load = 1'b1;
    @(negedge clock);
    vec_load = 1'b0;
  endtask

  // Observes the scan at each negedge, picks idx_ready for the next edge,
  // records transfers, and stops at done (bounded by a cycle budget).
  // mode 0: always ready, mode 1: random ready; ready_pat entries go first.
  task automatic collect(input int mode);
    bit       prev_stall;
    bit       fin;
    bit       r;
    logic [3:0] prev_idx;
    got_q.delete();
    got_cnt    = -1;
    cycles     = 0;
    prev_stall = 1'b0;
    prev_idx   = '0;
    fin        = 1'b0;
    while (!fin && cycles < 200) begin
      if (prev_stall) check("stall_idx_held", idx_out, prev_idx);
      if (done) begin
        check("done_valid_low", idx_valid, 0);
        check("done_load_ready_low", load_ready, 0);
        got_cnt   = count_out;
        idx_ready = 1'b0;
        fin       = 1'b1;
      end else begin
        check("valid_until_done", idx_valid, 1);
        if (ready_pat.size() > 0) r = ready_pat.pop_front();
        else if (mode == 1)       r = 1'($urandom_range(0, 1));
        else                      r = 1'b1;
        idx_ready = r;
        if (idx_valid && r) got_q.push_back(int'(idx_out));
        prev_stall = idx_valid && !r;
        prev_idx   = idx_out;
        cycles++;
        @(negedge clock);
      end
    end
    if (!fin) check("done_timeout", 0, 1);
    // Leave DONE: the cycle after the pulse must be idle again.
    @(negedge clock);
    vec_load = 1'b0;
    check("idle_after_done_ready", load_ready, 1);
    check("idle_after_done_pulse", done, 0);
    check("count_held_in_idle", count_out, got_cnt);
  endtask

  initial begin
    logic [15:0] rv;
    reset     = 1'b1;
    vec_in    = '0;
    vec_load  = 1'b0;
    idx_ready = 1'b0;

    tbl.push_back('{16'h0000,  0, -1, -1});
    tbl.push_back('{16'h0124,  3,  2,  8});
    tbl.push_back('{16'hFFFF, 16,  0, 15});
    tbl.push_back('{16'h0001,  1,  0,  0});
    tbl.push_back('{16'h8000,  1, 15, 15});
    tbl.push_back('{16'h5555,  8,  0, 14});
    tbl.push_back('{16'h00F0,  4,  4,  7});

    #3;
    check("rst_load_ready", load_ready, 1);
    check("rst_idx_valid", idx_valid, 0);
    check("rst_idx_out", idx_out, 0);
    check("rst_done", done, 0);
    check("rst_count_out", count_out, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // Table: always-ready consumer, one index per cycle, k cycles then done.
    foreach (tbl[t]) begin
      drive_load(tbl[t].vec);
      collect(0);
      build_expected(tbl[t].vec);
      compare_lists($sformatf("tbl%0d", t));
      check($sformatf("tbl%0d_count_const", t), got_cnt, tbl[t].exp_cnt);
      check($sformatf("tbl%0d_cycles", t), cycles, tbl[t].exp_cnt);
      if (tbl[t].exp_cnt > 0) begin
        check($sformatf("tbl%0d_first", t), got_q.size() > 0 ? got_q[0] : -1,
              tbl[t].exp_first);
        check($sformatf("tbl%0d_last", t),
              got_q.size() > 0 ? got_q[got_q.size()-1] : -1, tbl[t].exp_last);
      end
    end

    // Stalls: ready 0,0,1,0,1 on 16'h8001.
    ready_pat = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    drive_load(16'h8001);
    collect(0);
    build_expected(16'h8001);
    compare_lists("stall8001");
    check("stall8001_cycles", cycles, 5);

    // Loads during EMIT and DONE are ignored.
    drive_load(16'h00F0);
    vec_in   = 16'h0003;
    vec_load = 1'b1;
    collect(0);
    build_expected(16'h00F0);
    compare_lists("ignore_load");
    @(negedge clock);
    check("ignore_load_no_valid", idx_valid, 0);
    check("ignore_load_idle", load_ready, 1);

    // Asynchronous reset mid-scan.
    drive_load(16'h0F00);
    check("rst_scan_first", idx_out, 8);
    idx_ready = 1'b1;
    @(negedge clock);
    check("rst_scan_second", idx_out, 9);
    idx_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("midrst_idx_valid", idx_valid, 0);
    check("midrst_idx_out", idx_out, 0);
    check("midrst_load_ready", load_ready, 1);
    check("midrst_done", done, 0);
    check("midrst_count_out", count_out, 0);
    @(negedge clock);
    reset = 1'b0;
    check("midrst_no_done", done, 0);
    @(negedge clock);
    drive_load(16'h0002);
    collect(0);
    build_expected(16'h0002);
    compare_lists("after_rst");

    // Randomized vectors with random back-pressure.
    for (int n = 0; n < 40; n++) begin
      rv = 16'($urandom);
      if (n % 10 == 3) rv = rv & 16'($urandom);
      drive_load(rv);
      collect(1);
      build_expected(rv);
      compare_lists($sformatf("rnd%0d", n));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Inverse of the team's shift-based binary-to-one-hot decoder. Accepts a 16-bit request vector and emits the binary index of every set bit, lowest first, one per handshake.
- Emits a done pulse with the bit count once the vector is drained.
- Sits between switch/request capture logic and index consumers (LED/7-seg drivers, arbiter logic). Also usable as a strict priority encoder by taking only the first index.

Parameters:
- IDX_W, 4, index width. Vector width VEC_W = 1<<IDX_W is a derived localparam and is not overridable.

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- vec_in  in  VEC_W  request vector, sampled only when vec_load & load_ready
- vec_load  in  1  load strobe
- load_ready  out  1  high only in IDLE
- idx_out  out  IDX_W  index of current lowest pending bit (registered)
- idx_valid  out  1  idx_out is valid
- idx_ready  in  1  consumer accepts idx_out this cycle
- done  out  1  one-cycle pulse after the last index is accepted (or after an empty load)
- count_out  out  IDX_W+1  number of indices emitted for the last vector; valid while done=1, held until next load

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, pending=0, idx_out=0, idx_valid=0, done=0, count_out=0, load_ready=1. Reset mid-scan discards pending bits and emits no done pulse.
- States: IDLE, EMIT, DONE.
- IDLE:
  - load_ready=1.
  - On vec_load with vec_in!=0: pending<=vec_in, idx_out<=penc(vec_in), cnt<=0, idx_valid<=1, go to EMIT.
  - On vec_load with vec_in==0: cnt<=0, go to DONE.
  - Without vec_load: stay in IDLE.
- Latency: load accepted in cycle N -> idx_valid=1 in cycle N+1.
- EMIT:
  - load_ready=0; vec_load is ignored.
  - Transfer occurs when idx_valid & idx_ready. On transfer: pending_n = pending & ~(1<<idx_out), pending<=pending_n, cnt<=cnt+1.
  - If pending_n!=0: idx_out<=penc(pending_n), idx_valid stays 1. This gives back-to-back transfers, one per cycle.
  - If pending_n==0: idx_valid<=0, go to DONE.
  - With idx_ready=0: idx_out and idx_valid are held stable. Once asserted, idx_valid must not drop without a transfer.
- DONE (exactly one cycle):
  - done=1, count_out=cnt, load_ready=0, idx_valid=0.
  - Next state is IDLE. A vec_load during DONE is ignored.
- penc: lowest set bit wins. It is never evaluated on a zero vector in EMIT; idx_out keeps its last value when idx_valid=0.
- Width rules:
  - cnt and count_out are IDX_W+1 bits, so the all-ones vector gives count 16 with no wrap.
  - Indices 0..VEC_W-1 fit IDX_W bits exactly.
- Throughput: a vector with k set bits, consumer always ready, takes k EMIT cycles plus 1 DONE cycle plus 1 IDLE cycle before the next load.

Decomposition:
- Shared include file (team header): IDX_W default, the state encodings ST_IDLE/ST_EMIT/ST_DONE (2-bit localparams), and the VEC_W derivation.
- One sub-module, prio_enc_lsb:
  - Purely combinational, parameterised by IDX_W.
  - Inputs: vec[VEC_W-1:0]. Outputs: idx[IDX_W-1:0] (lowest set bit) and any.
  - Instantiated twice: once on vec_in for the load path, once on pending_n for the accept path.
- The rest (FSM, pending register, counter) lives in the top module.

Test Plan:
- Load 16'h0000, idx_ready=1 -> no idx_valid; done=1 one cycle after load with count_out=0; load_ready back to 1 the next cycle.
- Load 16'h0124, idx_ready=1 -> idx_out 2, 5, 8 on three consecutive cycles starting one cycle after load; done with count_out=3 in the following cycle.
- Load 16'hFFFF, idx_ready=1 -> indices 0..15 in order on 16 consecutive cycles; count_out=16 (5'b10000).
- Load 16'h8001, idx_ready toggling 0,0,1,0,1 -> idx_out=0 held through the stall cycles, then 15, then done with count_out=2; idx_valid never drops before a transfer.
- Load 16'h00F0, then assert vec_load with 16'h0003 during EMIT and during DONE -> second load ignored; output sequence 4,5,6,7 and count_out=4 only.
- Load 16'h0F00, accept one index (8), assert reset asynchronously mid-cycle -> all outputs go to reset values immediately, no done pulse; a subsequent load of 16'h0002 yields idx 1 and count_out=1.
